// File: rtl/apb_timer_array.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_timer_array
//
// Array of N_CH independent compare timers behind a zero-wait-state APB slave.
// Each channel occupies a 16-byte window at n*0x10:
//   0x0 CTRL   : [0] EN, [1] ONESHOT, [2] IRQ_EN, [15:8] PRESCALE
//   0x4 CNT    : counter, CNT_WIDTH bits, upper bits read 0
//   0x8 CMP    : compare value, CNT_WIDTH bits, upper bits read 0
//   0xC STATUS : [0] MATCH, write-1-to-clear
//
// Optional feature macro: APB_TIMER_ARRAY_PRESCALER_EN
//   defined   -> each channel has an 8-bit prescale counter; a tick occurs
//                when it equals CTRL.PRESCALE.
//   undefined -> PRESCALE reads 0 and ignores writes, a tick occurs on every
//                cycle with EN=1.
//
// Parameters:
//   N_CH           number of timer channels (1..8)
//   CNT_WIDTH      counter / compare width (8..32)
//   APB_ADDR_WIDTH width of PADDR
//
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE   APB request
//   PRDATA, PREADY, PSLVERR                APB response (PREADY tied 1)
//   irq_o          per-channel level interrupt = MATCH & IRQ_EN
// ---------------------------------------------------------------------------
module apb_timer_array #(
   parameter int N_CH           = 4,
   parameter int CNT_WIDTH      = 32,
   parameter int APB_ADDR_WIDTH = 12
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [N_CH-1:0]           irq_o
);

   localparam logic [1:0] OFF_CTRL = 2'd0;
   localparam logic [1:0] OFF_CNT  = 2'd1;
   localparam logic [1:0] OFF_CMP  = 2'd2;
   localparam logic [1:0] OFF_STAT = 2'd3;

   // Address decode. PADDR[1:0] is ignored, so byte offsets 0xD..0xF alias
   // STATUS; the only illegal accesses are those to a missing channel.
   logic [31:0] ch_idx;
   logic [1:0]  reg_off;
   logic        ch_valid;
   logic        acc_en;
   logic        wr_en;

   assign ch_idx   = 32'(PADDR[APB_ADDR_WIDTH-1:4]);
   assign reg_off  = PADDR[3:2];
   assign ch_valid = (ch_idx < 32'(N_CH));
   assign acc_en   = PSEL & PENABLE;
   assign wr_en    = acc_en & PWRITE & ch_valid;

   assign PREADY  = 1'b1;
   assign PSLVERR = acc_en & ~ch_valid;

   // Per-channel readback words, gathered by the read mux below.
   logic [31:0] ctrl_rd [N_CH];
   logic [31:0] cnt_rd  [N_CH];
   logic [31:0] cmp_rd  [N_CH];
   logic [31:0] stat_rd [N_CH];

   for (genvar n = 0; n < N_CH; n++) begin : g_ch
      logic                 sel_ch;
      logic                 wr_ctrl;
      logic                 wr_cnt;
      logic                 wr_cmp;
      logic                 wr_stat;
      logic                 tick;
      logic                 hit;
      logic                 en_r;
      logic                 oneshot_r;
      logic                 irq_en_r;
      logic                 match_r;
      logic [CNT_WIDTH-1:0] cnt_r;
      logic [CNT_WIDTH-1:0] cmp_r;
      logic [7:0]           presc_rd;

      assign sel_ch  = wr_en & (ch_idx == 32'(n));
      assign wr_ctrl = sel_ch & (reg_off == OFF_CTRL);
      assign wr_cnt  = sel_ch & (reg_off == OFF_CNT);
      assign wr_cmp  = sel_ch & (reg_off == OFF_CMP);
      assign wr_stat = sel_ch & (reg_off == OFF_STAT);

`ifdef APB_TIMER_ARRAY_PRESCALER_EN
      logic [7:0] presc_r;
      logic [7:0] psc_cnt_r;

      assign tick     = en_r & (psc_cnt_r == presc_r);
      assign presc_rd = presc_r;

      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            presc_r <= 8'd0;
         end else if (wr_ctrl) begin
            presc_r <= PWDATA[15:8];
         end
      end

      // Held at 0 while disabled, so an EN 0->1 write always starts a
      // fresh prescale period without extra logic.
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            psc_cnt_r <= 8'd0;
         end else if (!en_r || tick) begin
            psc_cnt_r <= 8'd0;
         end else begin
            psc_cnt_r <= psc_cnt_r + 8'd1;
         end
      end
`else
      assign tick     = en_r;
      assign presc_rd = 8'd0;
`endif

      // Match decision always uses the counter value before any APB write.
      assign hit = tick & (cnt_r == cmp_r);

      // CTRL: an APB write in the same edge as a one-shot stop wins.
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            en_r      <= 1'b0;
            oneshot_r <= 1'b0;
            irq_en_r  <= 1'b0;
         end else if (wr_ctrl) begin
            en_r      <= PWDATA[0];
            oneshot_r <= PWDATA[1];
            irq_en_r  <= PWDATA[2];
         end else if (hit && oneshot_r) begin
            en_r      <= 1'b0;
         end
      end

      // CNT: APB write beats the tick update.
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            cnt_r <= '0;
         end else if (wr_cnt) begin
            cnt_r <= PWDATA[CNT_WIDTH-1:0];
         end else if (hit) begin
            cnt_r <= '0;
         end else if (tick) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
         end
      end

      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            cmp_r <= '0;
         end else if (wr_cmp) begin
            cmp_r <= PWDATA[CNT_WIDTH-1:0];
         end
      end

      // MATCH: a new match in the same edge as a W1C keeps the flag set.
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            match_r <= 1'b0;
         end else if (hit) begin
            match_r <= 1'b1;
         end else if (wr_stat && PWDATA[0]) begin
            match_r <= 1'b0;
         end
      end

      assign ctrl_rd[n] = {16'd0, presc_rd, 5'd0, irq_en_r, oneshot_r, en_r};
      assign cnt_rd[n]  = 32'(cnt_r);
      assign cmp_rd[n]  = 32'(cmp_r);
      assign stat_rd[n] = {31'd0, match_r};
      assign irq_o[n]   = match_r & irq_en_r;
   end

   // Read mux: combinational, valid throughout the access phase. Illegal
   // channels fall through to zero.
   always_comb begin
      PRDATA = 32'd0;
      if (PSEL && ch_valid) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == 32'(i)) begin
               case (reg_off)
                  OFF_CTRL: PRDATA = ctrl_rd[i];
                  OFF_CNT:  PRDATA = cnt_rd[i];
                  OFF_CMP:  PRDATA = cmp_rd[i];
                  default:  PRDATA = stat_rd[i];
               endcase
            end
         end
      end
   end

   // Byte-lane address bits and write-data bits beyond the implemented
   // fields have no function.
   logic unused_bits;
   assign unused_bits = ^{PADDR[1:0], PWDATA};

endmodule
